// File: rtl/sound_sequencer.sv
// sound_sequencer: fixed-priority game sound player stepping a melody ROM into the buzzer.
// Define SOUND_PREEMPT_EN to let a strictly higher-priority request abort the current melody.
//
// state | meaning
// IDLE  | silent, all outputs 0, waiting for a pending request
// LOAD  | fetch the current ROM entry, buzzer disabled
// PLAY  | sound the entry note for dur*TICK_CLKS cycles
// GAP   | silent spacing between notes, note code held
module sound_sequencer #(
    parameter int TICK_CLKS = 250000,
    parameter int GAP_CLKS  = 125000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_drop,
    input  logic       req_error,
    input  logic       req_win,
    output logic [3:0] note,
    output logic       enable,
    output logic       busy,
    output logic [1:0] playing_id,
    output logic       done
);
    localparam int MAX_CNT = (15 * TICK_CLKS > GAP_CLKS) ? 15 * TICK_CLKS : GAP_CLKS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [3:0]       addr_q, addr_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       note_q, note_d;
    logic             enable_q, enable_d;
    logic [1:0]       id_q, id_d;
    logic             done_q, done_d;

    logic [8:0] entry;
    logic [3:0] entry_dur;
    logic [1:0] hi_id;
    logic [3:0] hi_base;
    logic [2:0] hi_mask;
    logic [2:0] clr_mask;
    logic       preempt;

    // ROM entry {note, dur, last}; melodies packed back to back: DROP @0, ERROR @2, WIN @5
    always_comb begin
        case (addr_q)
            4'd0:    entry = {4'd8,  4'd3,  1'b0};
            4'd1:    entry = {4'd1,  4'd3,  1'b1};
            4'd2:    entry = {4'd9,  4'd10, 1'b0};
            4'd3:    entry = {4'd0,  4'd3,  1'b0};
            4'd4:    entry = {4'd10, 4'd15, 1'b1};
            4'd5:    entry = {4'd1,  4'd6,  1'b0};
            4'd6:    entry = {4'd3,  4'd6,  1'b0};
            4'd7:    entry = {4'd5,  4'd6,  1'b0};
            4'd8:    entry = {4'd7,  4'd12, 1'b0};
            4'd9:    entry = {4'd0,  4'd3,  1'b0};
            4'd10:   entry = {4'd5,  4'd6,  1'b0};
            4'd11:   entry = {4'd7,  4'd15, 1'b1};
            default: entry = {4'd0,  4'd1,  1'b1};
        endcase
    end

    assign entry_dur = (entry[4:1] == 4'd0) ? 4'd1 : entry[4:1];

    always_comb begin
        hi_id   = 2'd0;
        hi_base = 4'd0;
        hi_mask = 3'b000;
        if (pend_q[2]) begin
            hi_id = 2'd3; hi_base = 4'd5; hi_mask = 3'b100;
        end else if (pend_q[1]) begin
            hi_id = 2'd2; hi_base = 4'd2; hi_mask = 3'b010;
        end else if (pend_q[0]) begin
            hi_id = 2'd1; hi_base = 4'd0; hi_mask = 3'b001;
        end
    end

`ifdef SOUND_PREEMPT_EN
    assign preempt = (state_q != S_IDLE) && (hi_id > id_q);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        timer_d  = timer_q;
        note_d   = note_q;
        enable_d = enable_q;
        id_d     = id_q;
        done_d   = 1'b0;
        clr_mask = 3'b000;
        if (preempt) begin
            state_d  = S_LOAD;
            addr_d   = hi_base;
            id_d     = hi_id;
            enable_d = 1'b0;
            clr_mask = hi_mask;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hi_id != 2'd0) begin
                        state_d  = S_LOAD;
                        addr_d   = hi_base;
                        id_d     = hi_id;
                        clr_mask = hi_mask;
                    end
                end
                S_LOAD: begin
                    state_d  = S_PLAY;
                    timer_d  = CNT_W'(entry_dur) * CNT_W'(TICK_CLKS) - CNT_W'(1);
                    note_d   = entry[8:5];
                    enable_d = (entry[8:5] != 4'd0);
                end
                S_PLAY: begin
                    if (timer_q == '0) begin
                        enable_d = 1'b0;
                        if (entry[0]) begin
                            state_d = S_IDLE;
                            note_d  = 4'd0;
                            id_d    = 2'd0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + 4'd1;
                            if (GAP_CLKS > 0) begin
                                state_d = S_GAP;
                                timer_d = CNT_W'(GAP_CLKS - 1);
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q == '0) state_d = S_LOAD;
                    else               timer_d = timer_q - CNT_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
        // a request on the loading edge wins over the clear so the melody replays
        pend_d = (pend_q & ~clr_mask) | {req_win, req_error, req_drop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pend_q   <= 3'b000;
            addr_q   <= 4'd0;
            timer_q  <= '0;
            note_q   <= 4'd0;
            enable_q <= 1'b0;
            id_q     <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            addr_q   <= addr_d;
            timer_q  <= timer_d;
            note_q   <= note_d;
            enable_q <= enable_d;
            id_q     <= id_d;
            done_q   <= done_d;
        end
    end

    assign note       = note_q;
    assign enable     = enable_q;
    assign busy       = (state_q != S_IDLE);
    assign playing_id = id_q;
    assign done       = done_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: vector table, corner sequences and random requests checked
// against a melody-timeline reference model; SOUND_PREEMPT_EN selects the preemption variant.
module tb_sound_sequencer;
    localparam int TICK = 4;
    localparam int GAP  = 2;
`ifdef SOUND_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_drop = 1'b0, req_error = 1'b0, req_win = 1'b0;
    logic [3:0] note;
    logic       enable, busy, done;
    logic [1:0] playing_id;

    sound_sequencer #(.TICK_CLKS(TICK), .GAP_CLKS(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_drop(req_drop), .req_error(req_error), .req_win(req_win),
        .note(note), .enable(enable), .busy(busy),
        .playing_id(playing_id), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] note;
        logic       en;
        logic       busy;
        logic [1:0] id;
        logic       done;
    } out_t;

    typedef struct {
        logic [2:0] req;
        int         n;
        out_t       e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // melody tables indexed by id-1: DROP, ERROR, WIN
    int mel_note [3][7] = '{'{8, 1, 0, 0, 0, 0, 0}, '{9, 0, 10, 0, 0, 0, 0}, '{1, 3, 5, 7, 0, 5, 7}};
    int mel_dur  [3][7] = '{'{3, 3, 0, 0, 0, 0, 0}, '{10, 3, 15, 0, 0, 0, 0}, '{6, 6, 6, 12, 3, 6, 15}};
    int mel_len  [3]    = '{2, 3, 7};

    out_t       exp_q[$];
    out_t       cur = '0;
    logic [2:0] m_pend = 3'b000;
    vec_t       tbl[$];

    function automatic out_t mk(input int n, input bit en, input bit bz, input int id, input bit dn);
        out_t o;
        o.note = 4'(n); o.en = en; o.busy = bz; o.id = 2'(id); o.done = dn;
        return o;
    endfunction

    function automatic int hi_of(input logic [2:0] p);
        if (p[2]) return 3;
        if (p[1]) return 2;
        if (p[0]) return 1;
        return 0;
    endfunction

    // expand a whole melody into its per-cycle output timeline, starting with its LOAD cycle
    task automatic build(input int id, input logic [3:0] held);
        int m, d, nt;
        m = id - 1;
        exp_q.delete();
        exp_q.push_back(mk(int'(held), 1'b0, 1'b1, id, 1'b0));
        for (int k = 0; k < mel_len[m]; k++) begin
            nt = mel_note[m][k];
            d  = (mel_dur[m][k] == 0) ? 1 : mel_dur[m][k];
            for (int c = 0; c < d * TICK; c++) exp_q.push_back(mk(nt, nt != 0, 1'b1, id, 1'b0));
            if (k == mel_len[m] - 1) exp_q.push_back(mk(0, 1'b0, 1'b0, 0, 1'b1));
            else for (int c = 0; c < GAP + 1; c++) exp_q.push_back(mk(nt, 1'b0, 1'b1, id, 1'b0));
        end
    endtask

    task automatic model_edge(input logic [2:0] r);
        int h;
        h = hi_of(m_pend);
        if (exp_q.size() != 0) begin
            if (PREEMPT && h > int'(cur.id)) begin
                m_pend = m_pend & ~(3'b001 << (h - 1));
                build(h, cur.note);
            end
            cur = exp_q.pop_front();
        end else if (h != 0) begin
            m_pend = m_pend & ~(3'b001 << (h - 1));
            build(h, 4'd0);
            cur = exp_q.pop_front();
        end else begin
            cur = '0;
        end
        m_pend = m_pend | r;
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur    = '0;
        m_pend = 3'b000;
    endtask

    task automatic expect_out(input string name, input out_t e);
        out_t a;
        a = {note, enable, busy, playing_id, done};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got note=%0d en=%0b busy=%0b id=%0d done=%0b, want note=%0d en=%0b busy=%0b id=%0d done=%0b",
                     name, $time, a.note, a.en, a.busy, a.id, a.done, e.note, e.en, e.busy, e.id, e.done);
        end
    endtask

    // drive requests for one edge, advance the model, check at the following negedge
    task automatic cycle(input logic [2:0] r);
        {req_win, req_error, req_drop} = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        expect_out("model", cur);
        {req_win, req_error, req_drop} = 3'b000;
    endtask

    function automatic void add(input logic [2:0] r, input int n, input out_t e);
        vec_t v;
        v.req = r; v.n = n; v.e = e;
        tbl.push_back(v);
    endfunction

    int dones;

    initial begin
        out_t z;
        z = mk(0, 1'b0, 1'b0, 0, 1'b0);
        add(3'b000, 20, z);
        // DROP
        add(3'b001, 1, z);
        add(3'b000, 1, mk(0, 0, 1, 1, 0));
        add(3'b000, 12, mk(8, 1, 1, 1, 0));
        add(3'b000, 3, mk(8, 0, 1, 1, 0));
        add(3'b000, 12, mk(1, 1, 1, 1, 0));
        add(3'b000, 1, mk(0, 0, 0, 0, 1));
        add(3'b000, 2, z);
        // ERROR
        add(3'b010, 1, z);
        add(3'b000, 1, mk(0, 0, 1, 2, 0));
        add(3'b000, 40, mk(9, 1, 1, 2, 0));
        add(3'b000, 3, mk(9, 0, 1, 2, 0));
        add(3'b000, 15, mk(0, 0, 1, 2, 0));
        add(3'b000, 60, mk(10, 1, 1, 2, 0));
        add(3'b000, 1, mk(0, 0, 0, 0, 1));
        add(3'b000, 1, z);
        // DROP and WIN on the same edge: WIN first, DROP right after WIN's done cycle
        add(3'b101, 1, z);
        add(3'b000, 1, mk(0, 0, 1, 3, 0));
        add(3'b000, 24, mk(1, 1, 1, 3, 0));
        add(3'b000, 3, mk(1, 0, 1, 3, 0));
        add(3'b000, 24, mk(3, 1, 1, 3, 0));
        add(3'b000, 3, mk(3, 0, 1, 3, 0));
        add(3'b000, 24, mk(5, 1, 1, 3, 0));
        add(3'b000, 3, mk(5, 0, 1, 3, 0));
        add(3'b000, 48, mk(7, 1, 1, 3, 0));
        add(3'b000, 3, mk(7, 0, 1, 3, 0));
        add(3'b000, 15, mk(0, 0, 1, 3, 0));
        add(3'b000, 24, mk(5, 1, 1, 3, 0));
        add(3'b000, 3, mk(5, 0, 1, 3, 0));
        add(3'b000, 60, mk(7, 1, 1, 3, 0));
        add(3'b000, 1, mk(0, 0, 0, 0, 1));
        add(3'b000, 1, mk(0, 0, 1, 1, 0));
        add(3'b000, 12, mk(8, 1, 1, 1, 0));
        add(3'b000, 3, mk(8, 0, 1, 1, 0));
        add(3'b000, 12, mk(1, 1, 1, 1, 0));
        add(3'b000, 1, mk(0, 0, 0, 0, 1));
        add(3'b000, 2, z);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", z);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                cycle((c == 0) ? tbl[i].req : 3'b000);
                expect_out($sformatf("tbl%0d.%0d", i, c), tbl[i].e);
            end
        end

        // WIN requested 5 cycles into DROP's first note
        cycle(3'b001);
        cycle(3'b000);
        expect_out("pre_load", mk(0, 0, 1, 1, 0));
        repeat (5) cycle(3'b000);
        cycle(3'b100);
        expect_out("pre_req", mk(8, 1, 1, 1, 0));
        cycle(3'b000);
`ifdef SOUND_PREEMPT_EN
        expect_out("pre_abort_load", mk(8, 0, 1, 3, 0));
        cycle(3'b000);
        expect_out("pre_win_note", mk(1, 1, 1, 3, 0));
`else
        expect_out("nopre_cont", mk(8, 1, 1, 1, 0));
        repeat (20) cycle(3'b000);
        cycle(3'b000);
        expect_out("nopre_drop_done", mk(0, 0, 0, 0, 1));
        cycle(3'b000);
        expect_out("nopre_win_load", mk(0, 0, 1, 3, 0));
`endif
        dones = 0;
        for (int c = 0; c < 240; c++) begin
            cycle(3'b000);
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL pre_done_count: got %0d done pulses, want 1", dones);
        end

        // asynchronous reset in the middle of WIN with DROP pending
        cycle(3'b100);
        repeat (10) cycle(3'b000);
        cycle(3'b001);
        expect_out("rst_pre", mk(1, 1, 1, 3, 0));
        #2 rst_n = 1'b0;
        #1 expect_out("rst_async", z);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) cycle(3'b000);
        expect_out("rst_no_resume", z);

        // random request traffic
        for (int c = 0; c < 4000; c++) begin
            logic [2:0] r;
            r[0] = ($urandom_range(0, 29) == 0);
            r[1] = ($urandom_range(0, 59) == 0);
            r[2] = ($urandom_range(0, 119) == 0);
            cycle(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
